// File: rtl/register_sequencer.sv
// Operand sequencer for the 64x16 single-port register file: reads one or two
// source operands for the ALU, then writes the result back to the destination.
module register_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 6,
    parameter int unsigned NPROT = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [AW-1:0]    dst,
    input  logic [AW-1:0]    src_s,
    input  logic [AW-1:0]    src_t,
    input  logic             need_t,
    input  logic             wb_en,
    input  logic [WIDTH-1:0] result,
    input  logic             result_valid,
    input  logic [WIDTH-1:0] reg_data,
    output logic [AW-1:0]    reg_sel,
    output logic [1:0]       reg_mode,
    output logic [WIDTH-1:0] reg_wdata,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_valid,
    output logic             ready,
    output logic             done
);

    // Register file mode encodings (regModeIn / regModeOut / idle)
    localparam logic [1:0] MODE_IN   = 2'b00;
    localparam logic [1:0] MODE_OUT  = 2'b01;
    localparam logic [1:0] MODE_IDLE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_S,
        S_RD_T,
        S_LAT_T,
        S_LAT_S,
        S_EXEC,
        S_WB
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [AW-1:0]    src_t_q, src_t_d;
    logic             need_t_q, need_t_d;
    logic             wb_en_q, wb_en_d;
    logic [AW-1:0]    sel_q, sel_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_valid_q, op_valid_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    // State and registered outputs; clear aborts any access in flight
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q    <= S_IDLE;
            dst_q      <= '0;
            src_t_q    <= '0;
            need_t_q   <= 1'b0;
            wb_en_q    <= 1'b0;
            sel_q      <= '0;
            mode_q     <= MODE_IDLE;
            wdata_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dst_q      <= dst_d;
            src_t_q    <= src_t_d;
            need_t_q   <= need_t_d;
            wb_en_q    <= wb_en_d;
            sel_q      <= sel_d;
            mode_q     <= mode_d;
            wdata_q    <= wdata_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    // Next state; outputs are computed for the state being entered
    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        src_t_d    = src_t_q;
        need_t_d   = need_t_q;
        wb_en_d    = wb_en_q;
        sel_d      = sel_q;
        mode_d     = MODE_IDLE;
        wdata_d    = wdata_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = 1'b0;
        ready_d    = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    dst_d    = dst;
                    src_t_d  = src_t;
                    need_t_d = need_t;
                    wb_en_d  = wb_en;
                    sel_d    = src_s;
                    mode_d   = MODE_OUT;
                    ready_d  = 1'b0;
                    state_d  = S_RD_S;
                end
            end
            S_RD_S: begin
                if (need_t_q) begin
                    sel_d   = src_t_q;
                    mode_d  = MODE_OUT;
                    state_d = S_RD_T;
                end else begin
                    state_d = S_LAT_S;
                end
            end
            S_RD_T: begin
                op_a_d  = reg_data;
                state_d = S_LAT_T;
            end
            S_LAT_T: begin
                op_b_d     = reg_data;
                op_valid_d = 1'b1;
                state_d    = S_EXEC;
            end
            S_LAT_S: begin
                op_a_d     = reg_data;
                op_b_d     = '0;
                op_valid_d = 1'b1;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                op_valid_d = 1'b1;
                if (result_valid) begin
                    wdata_d    = result;
                    op_valid_d = 1'b0;
                    if (wb_en_q) begin
                        sel_d   = dst_q;
                        // Constant registers are never written
                        mode_d  = (dst_q >= AW'(NPROT)) ? MODE_IN : MODE_IDLE;
                        state_d = S_WB;
                    end else begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WB: begin
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign reg_sel   = sel_q;
    assign reg_mode  = mode_q;
    assign reg_wdata = wdata_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_valid  = op_valid_q;
    assign ready     = ready_q;
    assign done      = done_q;

endmodule

// File: tb/tb_register_sequencer.sv
// Bench for register_sequencer: behavioural register file plus an array-based
// reference of register contents, directed cases followed by random instructions.
module tb_register_sequencer;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned AW    = 6;
    localparam int unsigned NPROT = 4;
    localparam logic [1:0] M_IN   = 2'b00;
    localparam logic [1:0] M_OUT  = 2'b01;
    localparam logic [1:0] M_IDLE = 2'b11;

    logic             clk = 1'b0;
    logic             clear, start, need_t, wb_en, result_valid;
    logic [AW-1:0]    dst, src_s, src_t;
    logic [WIDTH-1:0] result, reg_data;
    logic [AW-1:0]    reg_sel;
    logic [1:0]       reg_mode;
    logic [WIDTH-1:0] reg_wdata, op_a, op_b;
    logic             op_valid, ready, done;

    logic [WIDTH-1:0] rf_mem  [64];
    logic [WIDTH-1:0] ref_mem [64];
    logic             rf_load;
    int               in_cnt = 0;
    int               n_assert = 0;
    int               n_fail = 0;

    register_sequencer #(.WIDTH(WIDTH), .AW(AW), .NPROT(NPROT)) dut (
        .clk(clk), .clear(clear), .start(start), .dst(dst), .src_s(src_s),
        .src_t(src_t), .need_t(need_t), .wb_en(wb_en), .result(result),
        .result_valid(result_valid), .reg_data(reg_data), .reg_sel(reg_sel),
        .reg_mode(reg_mode), .reg_wdata(reg_wdata), .op_a(op_a), .op_b(op_b),
        .op_valid(op_valid), .ready(ready), .done(done)
    );

    always #5 clk = ~clk;

    // Single-port register file with registered data_out
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 64; i++) rf_mem[i] <= ref_mem[i];
        end else if (reg_mode == M_IN) begin
            rf_mem[reg_sel] <= reg_wdata;
        end
        if (reg_mode == M_OUT) reg_data <= rf_mem[reg_sel];
    end

    always @(posedge clk) if (reg_mode == M_IN) in_cnt <= in_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_sel", 32'(reg_sel), 32'd0);
        check("rst_mode", 32'(reg_mode), 32'(M_IDLE));
        check("rst_wdata", 32'(reg_wdata), 32'd0);
        check("rst_op_a", 32'(op_a), 32'd0);
        check("rst_op_b", 32'(op_b), 32'd0);
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
    endtask

    // One instruction. pre: start already driven in a done cycle.
    // hold: keep start high with scrambled fields and pulse result_valid in RD_S.
    task automatic run(input logic [AW-1:0] d, input logic [AW-1:0] s, input logic [AW-1:0] t,
                       input logic nt, input logic wb, input logic [WIDTH-1:0] res,
                       input int dly, input bit pre, input bit hold);
        int cyc;
        int in0;
        logic [WIDTH-1:0] ea, eb;
        logic writes;
        in0    = in_cnt;
        ea     = ref_mem[s];
        eb     = nt ? ref_mem[t] : '0;
        writes = wb && (d >= AW'(NPROT));
        check("ready_before", 32'(ready), 32'd1);
        if (!pre) begin
            start = 1'b1; dst = d; src_s = s; src_t = t; need_t = nt; wb_en = wb;
        end
        step();
        check("accept_ready", 32'(ready), 32'd0);
        check("accept_done", 32'(done), 32'd0);
        check("rd_s_sel", 32'(reg_sel), 32'(s));
        check("rd_s_mode", 32'(reg_mode), 32'(M_OUT));
        if (hold) begin
            result_valid = 1'b1;
            result = WIDTH'($urandom);
            dst = AW'($urandom); src_s = AW'($urandom); src_t = AW'($urandom);
            need_t = 1'($urandom); wb_en = 1'($urandom);
        end else begin
            start = 1'b0;
        end
        cyc = 0;
        while (op_valid !== 1'b1 && cyc < 8) begin
            step();
            cyc++;
            result_valid = 1'b0;
            if (cyc == 1 && nt) begin
                check("rd_t_sel", 32'(reg_sel), 32'(t));
                check("rd_t_mode", 32'(reg_mode), 32'(M_OUT));
            end
        end
        check("latency", 32'(cyc), nt ? 32'd3 : 32'd2);
        check("op_a", 32'(op_a), 32'(ea));
        check("op_b", 32'(op_b), 32'(eb));
        for (int k = 0; k < dly; k++) begin
            step();
            check("exec_wait_valid", 32'(op_valid), 32'd1);
            check("exec_wait_mode", 32'(reg_mode), 32'(M_IDLE));
        end
        result = res;
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        result = WIDTH'($urandom);
        check("exec_exit_valid", 32'(op_valid), 32'd0);
        check("wdata", 32'(reg_wdata), 32'(res));
        if (wb) begin
            check("wb_sel", 32'(reg_sel), 32'(d));
            check("wb_mode", 32'(reg_mode), writes ? 32'(M_IN) : 32'(M_IDLE));
            check("wb_done_low", 32'(done), 32'd0);
            if (writes) ref_mem[d] = res;
            step();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_ready", 32'(ready), 32'd1);
        check("write_cycles", 32'(in_cnt - in0), writes ? 32'd1 : 32'd0);
        check("rf_dst", 32'(rf_mem[d]), 32'(ref_mem[d]));
        if (!hold) begin
            step();
            check("done_one_cycle", 32'(done), 32'd0);
        end
    endtask

    initial begin
        int in0;
        bit pend;
        bit hold;
        clear = 1'b1; start = 1'b0; dst = '0; src_s = '0; src_t = '0;
        need_t = 1'b0; wb_en = 1'b0; result = '0; result_valid = 1'b0; rf_load = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = WIDTH'($urandom);
        ref_mem[0] = 16'h0000; ref_mem[1] = 16'h0001;
        ref_mem[2] = 16'h8000; ref_mem[3] = 16'hFFFF;
        ref_mem[5] = 16'h1234; ref_mem[6] = 16'hABCD;
        rf_load = 1'b1;
        step();
        rf_load = 1'b0;
        step();
        check_reset_values();
        clear = 1'b0;
        step();

        // Two sources, result in the same cycle op_valid rises
        run(6'd7, 6'd5, 6'd6, 1'b1, 1'b1, 16'hBE01, 0, 1'b0, 1'b0);
        check("two_src_r7", 32'(rf_mem[7]), 32'h0000BE01);
        run(6'd0, 6'd7, 6'd7, 1'b0, 1'b0, 16'h0000, 1, 1'b0, 1'b0);
        check("read_r7", 32'(op_a), 32'h0000BE01);
        run(6'd8, 6'd3, 6'd0, 1'b0, 1'b1, 16'h4321, 0, 1'b0, 1'b0);
        check("one_src_a", 32'(op_a), 32'h0000FFFF);
        check("one_src_b", 32'(op_b), 32'h00000000);
        run(6'd2, 6'd4, 6'd5, 1'b1, 1'b1, 16'h0055, 1, 1'b0, 1'b0);
        check("protected_r2", 32'(rf_mem[2]), 32'h00008000);
        run(6'd10, 6'd5, 6'd6, 1'b1, 1'b0, 16'h7777, 2, 1'b0, 1'b0);
        run(6'd6, 6'd6, 6'd6, 1'b1, 1'b1, 16'h0F0F, 0, 1'b0, 1'b0);

        // Clear in RD_T aborts the pending write
        in0 = in_cnt;
        start = 1'b1; dst = 6'd9; src_s = 6'd5; src_t = 6'd6; need_t = 1'b1; wb_en = 1'b1;
        step();
        start = 1'b0;
        step();
        check("pre_clear_sel", 32'(reg_sel), 32'd6);
        clear = 1'b1;
        #1;
        check_reset_values();
        step();
        clear = 1'b0;
        step();
        check("clear_no_write", 32'(in_cnt - in0), 32'd0);
        check("clear_r9", 32'(rf_mem[9]), 32'(ref_mem[9]));
        run(6'd9, 6'd5, 6'd3, 1'b1, 1'b1, 16'h2468, 1, 1'b0, 1'b0);

        // Back-to-back issue with start held
        run(6'd11, 6'd5, 6'd6, 1'b1, 1'b1, 16'hC0DE, 0, 1'b0, 1'b1);
        run(dst, src_s, src_t, need_t, wb_en, 16'h1357, 1, 1'b1, 1'b0);

        pend = 1'b0;
        for (int i = 0; i < 40; i++) begin
            hold = (i < 39) && ($urandom_range(0, 3) == 0);
            if (pend)
                run(dst, src_s, src_t, need_t, wb_en, WIDTH'($urandom),
                    int'($urandom_range(0, 2)), 1'b1, hold);
            else
                run(AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
                    WIDTH'($urandom), int'($urandom_range(0, 2)), 1'b0, hold);
            pend = hold;
        end
        for (int i = 0; i < 64; i++) check("final_rf", 32'(rf_mem[i]), 32'(ref_mem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
